bfloat_man_div: RTL and testbench

Sequential restoring divider for 9-bit bfloat16 mantissas with the hidden bit included. It is the inverse of the combinational mantissa multiplier.
- Computes the fixed-point quotient q = floor(a·512 / b) in Q1.9 form, one quotient bit per cycle.
- Sits in the divide path of the bfloat arithmetic unit. Exponent subtraction and normalisation are done outside this block.
- Uses a valid/ready handshake on both input and output.

---
 rtl/bfloat_man_div.sv | 152 +++++++++++++++
 tb/tb_bfloat_man_div.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bfloat_man_div.sv
// bfloat_man_div: sequential restoring divider for 9-bit bfloat16 mantissas
// (hidden bit included). Produces q = floor(a * 512 / b) in Q1.9, one quotient
// bit per cycle, MSB first. The latency from accept to out_valid is a fixed
// 10 cycles.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only while idle
//   a, b                dividend / divisor mantissas, Q1.8, sampled on accept
//   out_valid/out_ready output handshake; results are held until accepted
//   q                   quotient, Q1.9 (10'h200 = 1.0), 10'h3FF on dz/ovf
//   rem                 final partial remainder (< b)
//   sticky              rem != 0
//   dz                  divisor was zero
//   ovf                 quotient does not fit in 10 bits (a >= 2*b, b != 0)
module bfloat_man_div (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] q,
    output logic [8:0] rem,
    output logic       sticky,
    output logic       dz,
    output logic       ovf
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic [8:0]  b_q, b_d;
    logic [9:0]  r_q, r_d;
    logic [9:0]  acc_q, acc_d;
    logic [3:0]  k_q, k_d;
    logic        dz_flag_q, dz_flag_d;
    logic        ovf_flag_q, ovf_flag_d;
    logic [9:0]  q_q, q_d;
    logic [8:0]  rem_q, rem_d;
    logic        sticky_q, sticky_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;

    // Restoring step on the current partial remainder.
    logic        ge;
    logic [9:0]  r_sub;

    always_comb begin
        ge    = (r_q >= {1'b0, b_q});
        r_sub = ge ? (r_q - {1'b0, b_q}) : r_q;
    end

    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        r_d        = r_q;
        acc_d      = acc_q;
        k_d        = k_q;
        dz_flag_d  = dz_flag_q;
        ovf_flag_d = ovf_flag_q;
        q_d        = q_q;
        rem_d      = rem_q;
        sticky_d   = sticky_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    b_d        = b;
                    r_d        = {1'b0, a};
                    acc_d      = '0;
                    k_d        = 4'd9;
                    dz_flag_d  = (b == 9'd0);
                    // dz takes priority: ovf is only meaningful with b != 0.
                    ovf_flag_d = (b != 9'd0) && ({1'b0, a} >= {b, 1'b0});
                    state_d    = StCalc;
                end
            end
            StCalc: begin
                acc_d = {acc_q[8:0], ge};
                if (k_q != 4'd0) begin
                    // r_sub < b <= 511 here, so the shift cannot overflow.
                    r_d = {r_sub[8:0], 1'b0};
                    k_d = k_q - 4'd1;
                end else begin
                    r_d     = r_sub;
                    state_d = StDone;
                    dz_d    = dz_flag_q;
                    ovf_d   = ovf_flag_q;
                    if (dz_flag_q || ovf_flag_q) begin
                        q_d      = 10'h3FF;
                        rem_d    = 9'd0;
                        sticky_d = 1'b0;
                    end else begin
                        q_d      = {acc_q[8:0], ge};
                        rem_d    = r_sub[8:0];
                        sticky_d = (r_sub[8:0] != 9'd0);
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            b_q        <= '0;
            r_q        <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            dz_flag_q  <= 1'b0;
            ovf_flag_q <= 1'b0;
            q_q        <= '0;
            rem_q      <= '0;
            sticky_q   <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            r_q        <= r_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            dz_flag_q  <= dz_flag_d;
            ovf_flag_q <= ovf_flag_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            sticky_q   <= sticky_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign q         = q_q;
    assign rem       = rem_q;
    assign sticky    = sticky_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bfloat_man_div.sv
// Self-checking bench for bfloat_man_div: directed cases, backpressure,
// mid-operation reset and a randomised sweep against an arithmetic model.
module tb_bfloat_man_div;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] a;
    logic [8:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] q;
    logic [8:0] rem;
    logic       sticky;
    logic       dz;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    bfloat_man_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .rem       (rem),
        .sticky    (sticky),
        .dz        (dz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division of a * 512 by b.
    function automatic logic [22:0] ref_div(input int unsigned ra, input int unsigned rb);
        int unsigned qq, rr;
        logic        zz, oo;
        zz = (rb == 0);
        oo = (rb != 0) && (ra >= 2 * rb);
        if (zz || oo) begin
            qq = 10'h3FF;
            rr = 0;
        end else begin
            qq = (ra * 512) / rb;
            rr = (ra * 512) % rb;
        end
        // {q[9:0], rem[8:0], sticky, dz, ovf, pad}
        return {qq[9:0], rr[8:0], (rr != 0), zz, oo, 1'b0};
    endfunction

    // Drive one operation with out_ready high; returns outputs and latency.
    task automatic run_op(input logic [8:0] ia, input logic [8:0] ib,
                          output logic [22:0] got, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = ia;
        b         = ib;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = {q, rem, sticky, dz, ovf, 1'b0};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0",
                     in_ready, out_valid);
        end
        checks++;
        if ({q, rem, sticky, dz, ovf} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs: q=%h rem=%h sticky=%b dz=%b ovf=%b required all 0",
                     q, rem, sticky, dz, ovf);
        end
    endtask

    task automatic test_directed();
        logic [8:0]  ta [8] = '{9'd256, 9'd511, 9'd384, 9'd256, 9'd300, 9'd300, 9'd150, 9'd0};
        logic [8:0]  tb [8] = '{9'd256, 9'd256, 9'd256, 9'd511, 9'd0,   9'd100, 9'd100, 9'd300};
        logic [22:0] fixed [8] = '{
            {10'h200, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0},
            {10'h3FE, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0},
            {10'h300, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0},
            {10'h100, 9'd256, 1'b1, 1'b0, 1'b0, 1'b0},
            {10'h3FF, 9'd0,   1'b0, 1'b1, 1'b0, 1'b0},
            {10'h3FF, 9'd0,   1'b0, 1'b0, 1'b1, 1'b0},
            {10'h300, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0},
            {10'h000, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0}
        };
        logic [22:0] got;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb[i], got, lat);
            checks++;
            if (got !== fixed[i]) begin
                failures++;
                $display("FAIL directed_%0d a=%0d b=%0d: got q=%h rem=%0d st=%b dz=%b ovf=%b required q=%h rem=%0d st=%b dz=%b ovf=%b",
                         i, ta[i], tb[i], got[22:13], got[12:4], got[3], got[2], got[1],
                         fixed[i][22:13], fixed[i][12:4], fixed[i][3], fixed[i][2], fixed[i][1]);
            end
            checks++;
            if (lat !== 10) begin
                failures++;
                $display("FAIL latency_%0d: got %0d cycles required 10", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [21:0] held;
        logic [22:0] got;
        int          lat;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 9'd384;
        b         = 9'd256;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 10 || {q, rem} !== {10'h300, 9'd0}) begin
            failures++;
            $display("FAIL bp_result: lat=%0d q=%h rem=%0d required 10 / 300 / 0", lat, q, rem);
        end
        held = {q, rem, sticky, dz, ovf};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a        = 9'd300;
            b        = 9'd0;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {q, rem, sticky, dz, ovf} !== held) begin
                failures++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b outs=%h required 1/0/%h",
                         i, out_valid, in_ready, {q, rem, sticky, dz, ovf}, held);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        run_op(9'd256, 9'd511, got, lat);
        checks++;
        if (got !== ref_div(256, 511) || lat !== 10) begin
            failures++;
            $display("FAIL bp_next_op: got %h lat=%0d required %h lat=10",
                     got, lat, ref_div(256, 511));
        end
    endtask

    task automatic test_reset_mid_op();
        logic [22:0] got;
        int          lat;
        @(negedge clk);
        in_valid = 1'b1;
        a        = 9'd511;
        b        = 9'd300;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {q, rem, sticky, dz, ovf} !== 22'd0) begin
            failures++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b outs=%h required 0/1/0",
                     out_valid, in_ready, {q, rem, sticky, dz, ovf});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(9'd256, 9'd256, got, lat);
        checks++;
        if (got !== ref_div(256, 256) || lat !== 10) begin
            failures++;
            $display("FAIL post_reset_op: got %h lat=%0d required %h lat=10",
                     got, lat, ref_div(256, 256));
        end
    endtask

    task automatic test_random();
        logic [22:0] got;
        logic [22:0] want;
        logic [8:0]  ra, rb;
        int          lat;
        for (int i = 0; i < 400; i++) begin
            ra = $urandom_range(511, 0);
            if (i % 20 == 0)      rb = 9'd0;
            else if (i % 4 == 0)  rb = $urandom_range(255, 1);
            else                  rb = $urandom_range(511, 256);
            want = ref_div(ra, rb);
            run_op(ra, rb, got, lat);
            checks++;
            if (got !== want || lat !== 10) begin
                failures++;
                $display("FAIL random_%0d a=%0d b=%0d: got %h lat=%0d required %h lat=10",
                         i, ra, rb, got, lat, want);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #23;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
